multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore FSM control unit for a multicycle MIPS-style datapath.
//               Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
//               FETCH_WAIT adds memory-wait cycles to FETCH (legal 0..3).
//               Optional feature: define MC_BNE_EN to add bne (Op 000101).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FETCH_WAIT_C = 2'(FETCH_WAIT);

  state_t     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;

  // Raw (pre-reset-gating) control values produced by the decoder
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctl;
  logic       pcwrite, branch, illegal;

`ifdef MC_BNE_EN
  logic       bne_q, bne_d;
  logic       branch_ne;
`endif

  // State, fetch-wait counter (and bne flag) registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= 2'd0;
`ifdef MC_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
`ifdef MC_BNE_EN
      bne_q   <= bne_d;
`endif
    end
  end

  // Next-state and Moore output decode; Illegal is the only input-dependent flag
  always_comb begin
    state_d  = state_q;
    wcnt_d   = 2'd0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluctl   = 3'b000;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
`ifdef MC_BNE_EN
    bne_d     = bne_q;
    branch_ne = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluctl  = ALU_ADD;
        if (wcnt_q == FETCH_WAIT_C) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluctl  = ALU_ADD;
`ifdef MC_BNE_EN
        bne_d   = (Op == OP_BNE);
`endif
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = ALU_ADD;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        state_d = S_ALUWB;
        case (Funct)
          6'b100000: aluctl = ALU_ADD;
          6'b100010: aluctl = ALU_SUB;
          6'b100100: aluctl = ALU_AND;
          6'b100101: aluctl = ALU_OR;
          6'b101010: aluctl = ALU_SLT;
          default: begin
            aluctl  = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluctl  = ALU_SUB;
        pcsrc   = 2'b01;
`ifdef MC_BNE_EN
        branch_ne = bne_q;
        branch    = ~bne_q;
`else
        branch  = 1'b1;
`endif
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Selects come straight from the state; reset already holds FETCH values
  assign IorD       = iord;
  assign RegDst     = regdst;
  assign MemtoReg   = memtoreg;
  assign ALUSrcA    = alusrca;
  assign ALUSrcB    = alusrcb;
  assign PCSrc      = pcsrc;
  assign ALUControl = aluctl;

  // Write enables and Illegal are gated by reset so nothing writes while it is low
  assign MemWrite = memwrite & Reset;
  assign IRWrite  = irwrite  & Reset;
  assign RegWrite = regwrite & Reset;
  assign Illegal  = illegal  & Reset;
`ifdef MC_BNE_EN
  assign PCEn = Reset & (pcwrite | (branch & Zero) | (branch_ne & ~Zero));
`else
  assign PCEn = Reset & (pcwrite | (branch & Zero));
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Two instances
//               (FETCH_WAIT=0 and FETCH_WAIT=2) share the inputs; an
//               instruction-level model predicts each output word per cycle.
//               Honours MC_BNE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;

  logic       a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA, a_PCEn, a_Illegal;
  logic [1:0] a_ALUSrcB, a_PCSrc;
  logic [2:0] a_ALUControl;
  logic       b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_PCEn, b_Illegal;
  logic [1:0] b_ALUSrcB, b_PCSrc;
  logic [2:0] b_ALUControl;

  multicycle_controller #(.FETCH_WAIT(0)) u0 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(a_IorD), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegDst(a_RegDst),
    .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .PCSrc(a_PCSrc), .ALUControl(a_ALUControl), .PCEn(a_PCEn), .Illegal(a_Illegal)
  );

  multicycle_controller #(.FETCH_WAIT(2)) u2 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .PCSrc(b_PCSrc), .ALUControl(b_ALUControl), .PCEn(b_PCEn), .Illegal(b_Illegal)
  );

  // Output word: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUControl,PCEn,Illegal}
  logic [15:0] w0, w2;
  assign w0 = {a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA,
               a_ALUSrcB, a_PCSrc, a_ALUControl, a_PCEn, a_Illegal};
  assign w2 = {b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA,
               b_ALUSrcB, b_PCSrc, b_ALUControl, b_PCEn, b_Illegal};

  initial forever #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;
  logic [15:0] q0[$];
  logic [15:0] q2[$];
  logic [15:0] rst_w;

  function automatic logic [15:0] mk(input logic iord, memw, irw, regdst, m2r, regw, srca,
                                     input logic [1:0] srcb, pcsrc, input logic [2:0] aluc,
                                     input logic pcen, ill);
    return {iord, memw, irw, regdst, m2r, regw, srca, srcb, pcsrc, aluc, pcen, ill};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s op=%b funct=%b zero=%b cyc=%0d got=%b expected=%b",
               name, Op, Funct, Zero, cyc, got, exp);
    end
  endtask

  task automatic put(input int which, input logic [15:0] w);
    if (which == 0) q0.push_back(w);
    else            q2.push_back(w);
  endtask

  // Instruction-level model: expected output words for one whole instruction
  task automatic gen_instr(input int which, input int fw);
    logic       ill;
    logic [2:0] ac;
    logic       legal;
    for (int i = 0; i <= fw; i++)
      put(which, mk(0,0,1'(i==fw),0,0,0,0,2'b01,2'b00,3'b010,1'(i==fw),0));
    legal = (Op == 6'b100011) || (Op == 6'b101011) || (Op == 6'b000000) ||
            (Op == 6'b000100) || (Op == 6'b001000) || (Op == 6'b000010);
`ifdef MC_BNE_EN
    legal = legal || (Op == 6'b000101);
`endif
    put(which, mk(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,!legal));
    case (Op)
      6'b100011: begin
        put(which, mk(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
        put(which, mk(1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));
        put(which, mk(0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0));
      end
      6'b101011: begin
        put(which, mk(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
        put(which, mk(1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));
      end
      6'b000000: begin
        ill = 1'b0;
        case (Funct)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default: begin ac = 3'b010; ill = 1'b1; end
        endcase
        put(which, mk(0,0,0,0,0,0,1,2'b00,2'b00,ac,0,ill));
        put(which, mk(0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0));
      end
      6'b000100: put(which, mk(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,Zero,0));
`ifdef MC_BNE_EN
      6'b000101: put(which, mk(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,~Zero,0));
`endif
      6'b001000: begin
        put(which, mk(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
        put(which, mk(0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0));
      end
      6'b000010: put(which, mk(0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,0));
      default: ;
    endcase
  endtask

  // Compare both instances against the model every enabled cycle
  always @(negedge Clk) begin
    if (chk_en) begin
      cyc++;
      if (q0.size() == 0) check("u0_model_empty", w0, ~w0);
      else                check("u0_cycle", w0, q0.pop_front());
      if (q2.size() == 0) check("u2_model_empty", w2, ~w2);
      else                check("u2_cycle", w2, q2.pop_front());
    end
  end

  // Hold reset low for n cycles, checking the reset-state outputs
  task automatic hold_reset(input int n);
    chk_en = 1'b0;
    Reset  = 1'b0;
    repeat (n) begin
      @(negedge Clk); #1;
      check("rst_u0", w0, rst_w);
      check("rst_u2", w2, rst_w);
    end
  endtask

  // Release reset just after a rising edge and check n cycles against the model
  task automatic run_model(input int n);
    q0.delete(); q2.delete();
    while (q0.size() < n) gen_instr(0, 0);
    while (q2.size() < n) gen_instr(1, 2);
    @(posedge Clk); #1;
    Reset = 1'b1; chk_en = 1'b1; cyc = 0;
    repeat (n) @(posedge Clk);
    #1 chk_en = 1'b0; Reset = 1'b0;
  endtask

  task automatic seg(input logic [5:0] op, input logic [5:0] fn, input logic z);
    Op = op; Funct = fn; Zero = z;
    hold_reset(2);
    run_model(14);
  endtask

  // Release reset and stop at mid-cycle of cycle number n (model not running)
  task automatic goto_cycle(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    Op = op; Funct = fn; Zero = z;
    chk_en = 1'b0; Reset = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (n - 1) @(posedge Clk);
    @(negedge Clk); #1;
  endtask

  initial begin
    rst_w = mk(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);

    // Model-checked runs over every instruction class
    seg(6'b100011, 6'b000000, 1'b0);   // lw
    seg(6'b101011, 6'b000000, 1'b0);   // sw
    seg(6'b000000, 6'b100000, 1'b0);   // add
    seg(6'b000000, 6'b100010, 1'b0);   // sub
    seg(6'b000000, 6'b100100, 1'b0);   // and
    seg(6'b000000, 6'b100101, 1'b0);   // or
    seg(6'b000000, 6'b101010, 1'b0);   // slt
    seg(6'b000000, 6'b000111, 1'b0);   // bad funct
    seg(6'b000100, 6'b000000, 1'b1);   // beq taken
    seg(6'b000100, 6'b000000, 1'b0);   // beq not taken
    seg(6'b001000, 6'b000000, 1'b0);   // addi
    seg(6'b000010, 6'b000000, 1'b0);   // j
    seg(6'b111111, 6'b000000, 1'b0);   // illegal op
    seg(6'b000101, 6'b000000, 1'b0);   // bne (illegal unless enabled)
    seg(6'b000101, 6'b000000, 1'b1);

    // Hand-computed literal expectations
    goto_cycle(6'b100011, 6'd0, 1'b0, 1);
    check("lw_c1_irwrite", 16'(a_IRWrite), 16'd1);
    goto_cycle(6'b100011, 6'd0, 1'b0, 2);
    check("lw_c2_irwrite", 16'(a_IRWrite), 16'd0);
    goto_cycle(6'b100011, 6'd0, 1'b0, 5);
    check("lw_c5_regwrite_memtoreg", 16'({a_RegWrite, a_MemtoReg}), 16'd3);
    goto_cycle(6'b100011, 6'd0, 1'b0, 4);
    check("lw_c4_regwrite", 16'(a_RegWrite), 16'd0);
    goto_cycle(6'b000100, 6'd0, 1'b1, 3);
    check("beq_z1_pcen", 16'(a_PCEn), 16'd1);
    goto_cycle(6'b000100, 6'd0, 1'b0, 3);
    check("beq_z0_pcen", 16'(a_PCEn), 16'd0);
    goto_cycle(6'b000000, 6'b101010, 1'b0, 3);
    check("slt_aluctl", 16'(a_ALUControl), 16'd7);
    goto_cycle(6'b000000, 6'b101010, 1'b0, 4);
    check("slt_wb_regdst_regwrite", 16'({a_RegDst, a_RegWrite}), 16'd3);
    goto_cycle(6'b000000, 6'b000111, 1'b0, 3);
    check("rtype_bad_illegal", 16'(a_Illegal), 16'd1);
    goto_cycle(6'b111111, 6'd0, 1'b0, 2);
    check("badop_illegal", 16'({a_Illegal, a_RegWrite, a_MemWrite}), 16'd4);
    goto_cycle(6'b111111, 6'd0, 1'b0, 3);
    check("badop_back_to_fetch", 16'(a_IRWrite), 16'd1);
    goto_cycle(6'b100011, 6'd0, 1'b0, 2);
    check("fw2_c2_irwrite", 16'({b_IRWrite, b_PCEn}), 16'd0);
    goto_cycle(6'b100011, 6'd0, 1'b0, 3);
    check("fw2_c3_irwrite_pcen", 16'({b_IRWrite, b_PCEn}), 16'd3);
`ifdef MC_BNE_EN
    goto_cycle(6'b000101, 6'd0, 1'b0, 3);
    check("bne_z0_pcen", 16'(a_PCEn), 16'd1);
`else
    goto_cycle(6'b000101, 6'd0, 1'b0, 2);
    check("bne_disabled_illegal", 16'(a_Illegal), 16'd1);
`endif

    // Reset during MEMWR aborts the store; first cycle after release is FETCH
    goto_cycle(6'b101011, 6'd0, 1'b0, 4);
    check("sw_memwr_before_reset", 16'(a_MemWrite), 16'd1);
    #1 Reset = 1'b0;
    #1;
    check("sw_reset_memwrite_drop", 16'(a_MemWrite), 16'd0);
    check("sw_reset_u0_word", w0, rst_w);
    check("sw_reset_u2_word", w2, rst_w);
    run_model(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
